// File: rtl/triple_word_serializer.sv
// Triple-word serializer: accepts one {x, y, z} triple per handshake and
// emits the three words one per beat with lane index and last flag, while
// keeping a wrapping checksum of emitted words and a completed-triple count.
module triple_word_serializer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic [WIDTH-1:0] in_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_lane,
    output logic             out_last,
    output logic [WIDTH-1:0] checksum,
    output logic [CNT_W-1:0] triple_cnt
);

    localparam int unsigned LANE_W = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EMIT_X = 2'd1,
        EMIT_Y = 2'd2,
        EMIT_Z = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [WIDTH-1:0]    r_x;
    logic [WIDTH-1:0]    r_y;
    logic [WIDTH-1:0]    r_z;

    logic                w_in_ready;
    logic                w_accept;
    logic                w_fire;

    logic                w_next_valid;
    logic [WIDTH-1:0]    w_next_data;
    logic [LANE_W-1:0]   w_next_lane;
    logic                w_next_last;

    // Upstream may hand over a new triple while idle, or while the z beat
    // is leaving, so back-to-back triples stream with no bubble.
    assign w_in_ready = (r_state == IDLE) || ((r_state == EMIT_Z) && out_ready);
    assign in_ready   = w_in_ready;
    assign w_accept   = in_valid && w_in_ready;
    assign w_fire     = out_valid && out_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and next registered output values.
    always_comb begin
        w_next_state = r_state;
        w_next_valid = out_valid;
        w_next_data  = out_data;
        w_next_lane  = out_lane;
        w_next_last  = out_last;

        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = EMIT_X;
                end
            end
            EMIT_X: begin
                if (w_fire) begin
                    w_next_state = EMIT_Y;
                end
            end
            EMIT_Y: begin
                if (w_fire) begin
                    w_next_state = EMIT_Z;
                end
            end
            EMIT_Z: begin
                if (w_fire) begin
                    w_next_state = w_accept ? EMIT_X : IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase

        // Output word follows the state being entered; a freshly accepted
        // triple supplies x straight from the input since the holding
        // registers load on the same edge.
        unique case (w_next_state)
            IDLE: begin
                w_next_valid = 1'b0;
                w_next_lane  = LANE_W'(0);
                w_next_last  = 1'b0;
            end
            EMIT_X: begin
                w_next_valid = 1'b1;
                w_next_data  = w_accept ? in_x : r_x;
                w_next_lane  = LANE_W'(0);
                w_next_last  = 1'b0;
            end
            EMIT_Y: begin
                w_next_valid = 1'b1;
                w_next_data  = r_y;
                w_next_lane  = LANE_W'(1);
                w_next_last  = 1'b0;
            end
            EMIT_Z: begin
                w_next_valid = 1'b1;
                w_next_data  = r_z;
                w_next_lane  = LANE_W'(2);
                w_next_last  = 1'b1;
            end
            default: begin
                w_next_valid = 1'b0;
                w_next_lane  = LANE_W'(0);
                w_next_last  = 1'b0;
            end
        endcase
    end

    // Registered output stage; holds steady while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_lane  <= '0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= w_next_valid;
            out_data  <= w_next_data;
            out_lane  <= w_next_lane;
            out_last  <= w_next_last;
        end
    end

    // Holding registers capture the whole triple on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
            r_z <= '0;
        end else if (w_accept) begin
            r_x <= in_x;
            r_y <= in_y;
            r_z <= in_z;
        end
    end

    // Wrapping checksum of every word that leaves, and count of z beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum   <= '0;
            triple_cnt <= '0;
        end else if (w_fire) begin
            checksum <= checksum + out_data;
            if (out_last) begin
                triple_cnt <= triple_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_triple_word_serializer.sv
// Directed self-checking bench for triple_word_serializer.
module tb_triple_word_serializer;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             out_ready;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_y;
    logic [WIDTH-1:0] in_z;

    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_lane;
    logic             out_last;
    logic [WIDTH-1:0] checksum;
    logic [CNT_W-1:0] triple_cnt;

    logic             in_ready2;
    logic             out_valid2;
    logic [WIDTH-1:0] out_data2;
    logic [1:0]       out_lane2;
    logic             out_last2;
    logic [WIDTH-1:0] checksum2;
    logic [1:0]       triple_cnt2;

    int checks;
    int failures;

    triple_word_serializer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_z(in_z),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_lane(out_lane), .out_last(out_last),
        .checksum(checksum), .triple_cnt(triple_cnt)
    );

    // Narrow-counter copy sharing the same stimulus, for the counter wrap.
    triple_word_serializer #(.WIDTH(WIDTH), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_x(in_x), .in_y(in_y), .in_z(in_z),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .out_lane(out_lane2), .out_last(out_last2),
        .checksum(checksum2), .triple_cnt(triple_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_x      = '0;
        in_y      = '0;
        in_z      = '0;
        tick();
        rst = 1'b0;
    endtask

    // Present a triple for one cycle; returns one cycle after the accept edge.
    task automatic offer(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic [WIDTH-1:0] z);
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
        in_z     = z;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_x      = '0;
        in_y      = '0;
        in_z      = '0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'd0 || out_lane !== 2'd0 ||
            out_last !== 1'b0 || checksum !== 32'd0 || triple_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%b data=%0d lane=%0d last=%b sum=%0d cnt=%0d, required 0 0 0 0 0 0",
                     out_valid, out_data, out_lane, out_last, checksum, triple_cnt);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [WIDTH-1:0] exp_d [3];
        exp_d[0] = 32'd14; exp_d[1] = 32'd21; exp_d[2] = 32'd35;
        do_reset();
        offer(32'd14, 32'd21, 32'd35);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d[k] || out_lane !== 2'(k) ||
                out_last !== (k == 2)) begin
                failures++;
                $display("FAIL single_beat%0d: valid=%b data=%0d lane=%0d last=%b, required 1 %0d %0d %b",
                         k, out_valid, out_data, out_lane, out_last, exp_d[k], k, (k == 2));
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0 || checksum !== 32'd70 || triple_cnt !== 16'd1 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_end: valid=%b sum=%0d cnt=%0d in_ready=%b, required 0 70 1 1",
                     out_valid, checksum, triple_cnt, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] exp_d [6];
        exp_d[0] = 32'd2; exp_d[1] = 32'd3; exp_d[2] = 32'd5;
        exp_d[3] = 32'd4; exp_d[4] = 32'd6; exp_d[5] = 32'd10;
        do_reset();
        in_valid = 1'b1;
        in_x = 32'd2; in_y = 32'd3; in_z = 32'd5;
        tick();
        in_x = 32'd4; in_y = 32'd6; in_z = 32'd10;
        for (int k = 0; k < 6; k++) begin
            if (k == 3) in_valid = 1'b0;
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d[k] || out_lane !== 2'(k % 3) ||
                out_last !== (k % 3 == 2)) begin
                failures++;
                $display("FAIL b2b_beat%0d: valid=%b data=%0d lane=%0d last=%b, required 1 %0d %0d %b",
                         k, out_valid, out_data, out_lane, out_last, exp_d[k], k % 3, (k % 3 == 2));
            end
            if (k == 2) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_ready_on_z: got %b required 1", in_ready);
                end
            end
            if (k == 1) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_ready_on_y: got %b required 0", in_ready);
                end
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0 || checksum !== 32'd30 || triple_cnt !== 16'd2) begin
            failures++;
            $display("FAIL b2b_end: valid=%b sum=%0d cnt=%0d, required 0 30 2",
                     out_valid, checksum, triple_cnt);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        offer(32'd6, 32'd9, 32'd15);
        checks++;
        if (out_data !== 32'd6 || out_lane !== 2'd0) begin
            failures++;
            $display("FAIL bp_x: data=%0d lane=%0d, required 6 0", out_data, out_lane);
        end
        tick();
        out_ready = 1'b0;
        #1;
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'd9 || out_lane !== 2'd1 ||
                out_last !== 1'b0 || in_ready !== 1'b0 || checksum !== 32'd6) begin
                failures++;
                $display("FAIL bp_stall%0d: valid=%b data=%0d lane=%0d last=%b in_ready=%b sum=%0d, required 1 9 1 0 0 6",
                         j, out_valid, out_data, out_lane, out_last, in_ready, checksum);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_data !== 32'd15 || out_lane !== 2'd2 || out_last !== 1'b1 || checksum !== 32'd15) begin
            failures++;
            $display("FAIL bp_z: data=%0d lane=%0d last=%b sum=%0d, required 15 2 1 15",
                     out_data, out_lane, out_last, checksum);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || checksum !== 32'd30 || triple_cnt !== 16'd1) begin
            failures++;
            $display("FAIL bp_end: valid=%b sum=%0d cnt=%0d, required 0 30 1",
                     out_valid, checksum, triple_cnt);
        end
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] exp_d [3];
        exp_d[0] = 32'h0; exp_d[1] = 32'h8000_0000; exp_d[2] = 32'h8000_0000;
        do_reset();
        offer(32'h0, 32'h8000_0000, 32'h8000_0000);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ($isunknown({out_valid, out_data, out_lane, out_last, checksum, triple_cnt, in_ready}) !== 1'b0 ||
                out_data !== exp_d[k]) begin
                failures++;
                $display("FAIL wrap_beat%0d: data=%h sum=%h, required data %h and no X",
                         k, out_data, checksum, exp_d[k]);
            end
            tick();
        end
        checks++;
        if (checksum !== 32'd0 || triple_cnt !== 16'd1 ||
            $isunknown({out_valid, out_data, out_lane, out_last, checksum}) !== 1'b0) begin
            failures++;
            $display("FAIL wrap_end: sum=%h cnt=%0d, required 0 1", checksum, triple_cnt);
        end
    endtask

    task automatic test_async_reset();
        logic [WIDTH-1:0] exp_d [3];
        exp_d[0] = 32'd8; exp_d[1] = 32'd12; exp_d[2] = 32'd20;
        do_reset();
        offer(32'd10, 32'd15, 32'd25);
        tick();
        // Mid-EMIT_Y, assert reset between clock edges.
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'd0 || out_lane !== 2'd0 ||
            out_last !== 1'b0 || checksum !== 32'd0 || triple_cnt !== 16'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL async_reset: valid=%b data=%0d lane=%0d last=%b sum=%0d cnt=%0d in_ready=%b, required 0 0 0 0 0 0 1",
                     out_valid, out_data, out_lane, out_last, checksum, triple_cnt, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || checksum !== 32'd0) begin
            failures++;
            $display("FAIL async_no_replay: valid=%b sum=%0d, required 0 0", out_valid, checksum);
        end
        offer(32'd8, 32'd12, 32'd20);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d[k] || out_lane !== 2'(k)) begin
                failures++;
                $display("FAIL async_after_beat%0d: valid=%b data=%0d lane=%0d, required 1 %0d %0d",
                         k, out_valid, out_data, out_lane, exp_d[k], k);
            end
            tick();
        end
        checks++;
        if (checksum !== 32'd40 || triple_cnt !== 16'd1) begin
            failures++;
            $display("FAIL async_after_end: sum=%0d cnt=%0d, required 40 1", checksum, triple_cnt);
        end
    endtask

    task automatic test_cnt_wrap();
        logic [1:0] exp_c [5];
        exp_c[0] = 2'd1; exp_c[1] = 2'd2; exp_c[2] = 2'd3; exp_c[3] = 2'd0; exp_c[4] = 2'd1;
        do_reset();
        for (int t = 0; t < 5; t++) begin
            offer(32'(2 * (t + 1)), 32'(3 * (t + 1)), 32'(5 * (t + 1)));
            tick();
            tick();
            tick();
            checks++;
            if (triple_cnt2 !== exp_c[t] || triple_cnt !== 16'(t + 1)) begin
                failures++;
                $display("FAIL cnt_wrap%0d: narrow=%0d wide=%0d, required %0d %0d",
                         t, triple_cnt2, triple_cnt, exp_c[t], t + 1);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_wrap();
        test_async_reset();
        test_cnt_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
